// File: rtl/flexpad_pkg.sv
// rtl/flexpad_pkg.sv - keypad geometry constants and key-index helpers
// Shared by flexpad_scanner and flexpad_debounce. No ports.
package flexpad_pkg;

  localparam int NUM_ROWS   = 4;
  localparam int NUM_COLS   = 3;
  localparam int NUM_KEYS   = 12;
  localparam int KEY_CODE_W = 4;

  typedef struct packed {
    logic                  single;  // exactly one bit set
    logic [KEY_CODE_W-1:0] index;   // position of the (highest) set bit
  } onehot_t;

  // Key code of the switch at (row, col): row*3 + col.
  function automatic logic [KEY_CODE_W-1:0] key_code(input logic [1:0] row,
                                                     input logic [1:0] col);
    return ({2'b00, row} * 4'd3) + {2'b00, col};
  endfunction

  // Reports whether a snapshot holds exactly one key, and which one.
  function automatic onehot_t onehot_index(input logic [NUM_KEYS-1:0] v);
    onehot_t     res;
    int unsigned n;
    res = '0;
    n   = 0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (v[i]) begin
        n++;
        res.index = KEY_CODE_W'(i);
      end
    end
    res.single = (n == 1);
    return res;
  endfunction

endpackage

// File: rtl/flexpad_debounce.sv
// rtl/flexpad_debounce.sv - full-snapshot debouncer for the keypad scanner
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   scan_done  strobe, one cycle per completed 3-column scan
//   snapshot   12-bit pressed map of the scan that completes this cycle
//   stable     debounced pressed map (registered)
//   commit     high in the scan_done cycle where stable takes a new value
module flexpad_debounce
  import flexpad_pkg::*;
#(
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                scan_done,
  input  logic [NUM_KEYS-1:0] snapshot,
  output logic [NUM_KEYS-1:0] stable,
  output logic                commit
);

  localparam int             CW      = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_SCANS);

  logic [NUM_KEYS-1:0] candidate;
  logic [CW-1:0]       cnt;
  logic [CW-1:0]       cnt_next;

  // The candidate always becomes the newest snapshot, so the commit value is
  // the snapshot itself; cnt is the saturated length of the identical run.
  always_comb begin
    cnt_next = cnt;
    commit   = 1'b0;
    if (scan_done) begin
      if (snapshot != candidate) begin
        cnt_next = CW'(1);
      end else if (cnt != CNT_MAX) begin
        cnt_next = cnt + CW'(1);
      end
      commit = (cnt_next == CNT_MAX) && (snapshot != stable);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      candidate <= '0;
      cnt       <= '0;
      stable    <= '0;
    end else if (scan_done) begin
      candidate <= snapshot;
      cnt       <= cnt_next;
      if (commit) begin
        stable <= snapshot;
      end
    end
  end

endmodule

// File: rtl/flexpad_scanner.sv
// rtl/flexpad_scanner.sv - 3x4 keypad column scanner with debounced press events
// Ports:
//   CLK, RST    clock and synchronous active-high reset
//   KEYPAD_ROW  asynchronous pulled-up row inputs (0 = pressed in active column)
//   KEYPAD_COL  column drives, active column low
//   KEY_VALID   press event waiting in the one-entry buffer
//   KEY_CODE    key index row*3+col of the buffered event
//   KEY_READY   consumer accepts the buffered event
//   KEY_DOWN    at least one key held in the debounced state
//   OVERFLOW    sticky, an event was dropped because the buffer was full
module flexpad_scanner
  import flexpad_pkg::*;
#(
  parameter int SCAN_DIV       = 1024,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [NUM_ROWS-1:0]   KEYPAD_ROW,
  output logic [NUM_COLS-1:0]   KEYPAD_COL,
  output logic                  KEY_VALID,
  output logic [KEY_CODE_W-1:0] KEY_CODE,
  input  logic                  KEY_READY,
  output logic                  KEY_DOWN,
  output logic                  OVERFLOW
);

  localparam int            DW         = $clog2(SCAN_DIV);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);

  localparam logic [1:0] COL_0 = 2'd0;
  localparam logic [1:0] COL_2 = 2'd2;

  logic [NUM_ROWS-1:0] row_meta;
  logic [NUM_ROWS-1:0] row_sync;
  logic [DW-1:0]       dwell;
  logic [1:0]          col;
  logic [1:0]          col_next;
  logic [NUM_KEYS-1:0] snapshot;
  logic [NUM_KEYS-1:0] snap_full;
  logic [NUM_KEYS-1:0] stable;
  logic                dwell_end;
  logic                scan_done;
  logic                commit;
  logic                press_event;
  logic                transfer;
  onehot_t             hit;

  assign dwell_end = (dwell == DWELL_LAST);
  assign scan_done = dwell_end && (col == COL_2);
  assign col_next  = (col == COL_2) ? COL_0 : col + 2'd1;
  assign transfer  = KEY_VALID && KEY_READY;

  // Snapshot including this cycle's samples, so the column-2 bits taken on
  // the scan-complete cycle reach the debouncer without an extra scan delay.
  always_comb begin
    snap_full = snapshot;
    if (dwell_end) begin
      for (int r = 0; r < NUM_ROWS; r++) begin
        snap_full[key_code(2'(r), col)] = ~row_sync[r];
      end
    end
  end

  flexpad_debounce #(
    .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
  ) u_debounce (
    .clk      (CLK),
    .rst      (RST),
    .scan_done(scan_done),
    .snapshot (snap_full),
    .stable   (stable),
    .commit   (commit)
  );

  // Only a transition from nothing held to a single key is a press; releases,
  // chords and keys added under a held key are silent.
  assign hit         = onehot_index(snap_full);
  assign press_event = commit && (stable == '0) && hit.single;

  always_ff @(posedge CLK) begin
    if (RST) begin
      row_meta   <= '1;
      row_sync   <= '1;
      dwell      <= '0;
      col        <= COL_0;
      KEYPAD_COL <= 3'b110;
      snapshot   <= '0;
      KEY_VALID  <= 1'b0;
      KEY_CODE   <= '0;
      KEY_DOWN   <= 1'b0;
      OVERFLOW   <= 1'b0;
    end else begin
      row_meta <= KEYPAD_ROW;
      row_sync <= row_meta;
      snapshot <= snap_full;

      if (dwell_end) begin
        dwell      <= '0;
        col        <= col_next;
        KEYPAD_COL <= ~(3'b001 << col_next);
      end else begin
        dwell <= dwell + DW'(1);
      end

      // Follow the value stable takes at this edge so KEY_DOWN and KEY_VALID
      // rise together.
      KEY_DOWN <= commit ? (|snap_full) : (|stable);

      if (press_event) begin
        if (!KEY_VALID || transfer) begin
          KEY_VALID <= 1'b1;
          KEY_CODE  <= hit.index;
        end else begin
          OVERFLOW <= 1'b1;
        end
      end else if (transfer) begin
        KEY_VALID <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_flexpad_scanner.sv
// tb/tb_flexpad_scanner.sv - self-checking bench for flexpad_scanner
module tb_flexpad_scanner;

  localparam int SCAN_DIV = 4;
  localparam int DEB      = 3;
  localparam int SCAN_CYC = 3 * SCAN_DIV;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] keypad_row = 4'hF;
  logic [2:0] keypad_col;
  logic       key_valid;
  logic [3:0] key_code;
  logic       key_ready = 1'b0;
  logic       key_down;
  logic       overflow;

  flexpad_scanner #(
    .SCAN_DIV(SCAN_DIV),
    .DEBOUNCE_SCANS(DEB)
  ) dut (
    .CLK       (clk),
    .RST       (rst),
    .KEYPAD_ROW(keypad_row),
    .KEYPAD_COL(keypad_col),
    .KEY_VALID (key_valid),
    .KEY_CODE  (key_code),
    .KEY_READY (key_ready),
    .KEY_DOWN  (key_down),
    .OVERFLOW  (overflow)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          cyc    = 0;
  logic [11:0] pressed = '0;

  // reference model: per-scan snapshot history and the output buffer
  logic [11:0] hist[$];
  logic [11:0] m_stable;
  logic        m_valid;
  logic [3:0]  m_code;
  logic        m_ovf;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [2:0] col_pat(input int c);
    logic [2:0] p;
    p    = 3'b111;
    p[c] = 1'b0;
    return p;
  endfunction

  function automatic logic [3:0] index_of(input logic [11:0] v);
    logic [3:0] idx;
    idx = '0;
    for (int i = 0; i < 12; i++) if (v[i]) idx = 4'(i);
    return idx;
  endfunction

  // physical keypad: a row reads low when a pressed key joins it to a low column
  task automatic drive_rows();
    logic [3:0] rows;
    rows = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 3; c++)
        if (keypad_col[c] == 1'b0 && pressed[r*3+c]) rows[r] = 1'b0;
    keypad_row = rows;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    drive_rows();
    check_val("col", keypad_col, col_pat((cyc / SCAN_DIV) % 3));
  endtask

  task automatic model_reset();
    hist.delete();
    m_stable = '0;
    m_valid  = 1'b0;
    m_code   = '0;
    m_ovf    = 1'b0;
    cyc      = 0;
  endtask

  task automatic apply_reset(input int edges);
    rst = 1'b1;
    key_ready = 1'b0;
    repeat (edges) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    drive_rows();
    check_val("rst_col", keypad_col, 3'b110);
    check_val("rst_valid", key_valid, 1'b0);
    check_val("rst_code", key_code, 4'd0);
    check_val("rst_down", key_down, 1'b0);
    check_val("rst_ovf", overflow, 1'b0);
  endtask

  // mode 0: never ready, 1: ready all scan, 2: ready only on the scan-complete edge
  task automatic run_scan(input logic [11:0] keys, input int mode);
    logic xfer, commit, ev, same;
    pressed   = keys;
    drive_rows();
    key_ready = (mode == 1);
    if (mode == 1 && m_valid) m_valid = 1'b0;
    for (int i = 0; i < SCAN_CYC; i++) begin
      if (mode == 2 && i == SCAN_CYC - 1) key_ready = 1'b1;
      step();
      if (i == 0) check_val("valid_first", key_valid, m_valid);
    end
    hist.push_back(keys);
    if (hist.size() > DEB) void'(hist.pop_front());
    same = (hist.size() == DEB);
    foreach (hist[k]) if (hist[k] != keys) same = 1'b0;
    commit = same && (keys != m_stable);
    ev     = commit && (m_stable == '0) && ($countones(keys) == 1);
    xfer   = key_ready && m_valid;
    if (commit) m_stable = keys;
    if (ev) begin
      if (!m_valid || xfer) begin
        m_valid = 1'b1;
        m_code  = index_of(keys);
      end else begin
        m_ovf = 1'b1;
      end
    end else if (xfer) begin
      m_valid = 1'b0;
    end
    check_val("valid", key_valid, m_valid);
    check_val("code", key_code, m_code);
    check_val("down", key_down, m_stable != '0);
    check_val("ovf", overflow, m_ovf);
  endtask

  task automatic hold(input logic [11:0] keys, input int n, input int mode);
    for (int i = 0; i < n; i++) run_scan(keys, mode);
  endtask

  initial begin
    logic [11:0] keys;
    int          r;
    model_reset();
    apply_reset(2);

    // idle scanning
    hold('0, 3, 0);

    // single clean press of key 7, transfer, release
    hold(12'(1) << 7, 3, 0);
    check_val("press7_code", key_code, 4'd7);
    run_scan(12'(1) << 7, 1);
    hold('0, 3, 1);

    // bounce on key 0, then a clean hold
    for (int i = 0; i < 6; i++) run_scan((i % 2 == 0) ? 12'h001 : 12'h000, 0);
    hold(12'h001, 3, 0);
    hold('0, 3, 1);

    // chord of keys 4 and 9, then release 9 only
    hold((12'(1) << 4) | (12'(1) << 9), 3, 0);
    hold(12'(1) << 4, 3, 0);
    hold('0, 3, 0);

    // overflow: 3 buffered, 11 dropped
    hold(12'(1) << 3, 3, 0);
    hold('0, 3, 0);
    hold(12'(1) << 11, 3, 0);
    check_val("ovf_code", key_code, 4'd3);
    run_scan(12'(1) << 11, 1);
    hold('0, 3, 1);

    // reset in the middle of the second confirming scan
    run_scan(12'(1) << 5, 0);
    key_ready = 1'b0;
    repeat (SCAN_CYC / 2) step();
    apply_reset(1);
    hold(12'(1) << 5, 3, 0);
    hold('0, 3, 1);

    // refill in the same cycle as a transfer
    hold(12'(1) << 2, 3, 0);
    hold('0, 3, 0);
    hold(12'(1) << 10, 2, 0);
    run_scan(12'(1) << 10, 2);
    check_val("refill_code", key_code, 4'd10);
    run_scan(12'(1) << 10, 1);
    hold('0, 3, 1);

    // randomized key patterns, hold lengths and consumer behaviour
    for (int s = 0; s < 40; s++) begin
      r = $urandom_range(0, 99);
      if (r < 50)      keys = '0;
      else if (r < 85) keys = 12'(1) << $urandom_range(0, 11);
      else             keys = 12'($urandom);
      for (int h = 0; h < int'($urandom_range(1, 5)); h++)
        run_scan(keys, int'($urandom_range(0, 2)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
